// File: rtl/sb_ccff_param.sv
// Switch block: NUM_MUX routing muxes whose selects come from a serial ccff configuration chain.
// Define SB_CFG_SHADOW_EN to drive the muxes from a shadow register that cfg_commit loads.
module sb_ccff_param #(
    parameter int NUM_MUX    = 4,
    parameter int MUX_SIZE   = 4,
    parameter int CHAN_WIDTH = 9
) (
    input  logic                        prog_clk,
    input  logic                        prog_reset_n,
    input  logic                        ccff_head,
    input  logic                        ccff_en,
    input  logic                        cfg_commit,
    input  logic [NUM_MUX*MUX_SIZE-1:0] mux_in,
    input  logic [CHAN_WIDTH-1:0]       pass_in,
    output logic [NUM_MUX-1:0]          mux_out,
    output logic [CHAN_WIDTH-1:0]       pass_out,
    output logic                        ccff_tail,
    output logic                        cfg_done
);

    localparam int SEL_W      = (MUX_SIZE <= 2) ? 1 : $clog2(MUX_SIZE);
    localparam int TOTAL_BITS = NUM_MUX * SEL_W;
    localparam int CNT_W      = $clog2(TOTAL_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);

    typedef enum logic {
        LOAD  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state;
    logic [TOTAL_BITS-1:0]   chain;
    logic [TOTAL_BITS-1:0]   active;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic                    commit_ok;

    assign cnt_next = (bit_cnt == CNT_FULL) ? CNT_FULL : bit_cnt + CNT_W'(1);

`ifdef SB_CFG_SHADOW_EN
    logic [TOTAL_BITS-1:0] shadow;

    // Commit captures the chain as it stood before any same-cycle shift.
    assign commit_ok = cfg_commit && cfg_done;
    assign active    = shadow;

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            shadow <= '0;
        end else if (commit_ok) begin
            shadow <= chain;
        end
    end
`else
    logic unused_commit;

    assign commit_ok     = 1'b0;
    assign active        = chain;
    assign unused_commit = cfg_commit;
`endif

    // An accepted commit takes priority over counting a same-cycle shift.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state    <= LOAD;
            chain    <= '0;
            bit_cnt  <= '0;
            cfg_done <= 1'b0;
        end else begin
            if (ccff_en) begin
                chain <= (chain << 1) | TOTAL_BITS'(ccff_head);
            end
            if (commit_ok) begin
                state    <= LOAD;
                bit_cnt  <= '0;
                cfg_done <= 1'b0;
            end else if (ccff_en) begin
                bit_cnt <= cnt_next;
                case (state)
                    LOAD: begin
                        if (cnt_next == CNT_FULL) begin
                            state    <= READY;
                            cfg_done <= 1'b1;
                        end
                    end
                    READY: begin
                        cfg_done <= 1'b1;
                    end
                    default: begin
                        state <= LOAD;
                    end
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUM_MUX; k++) begin : g_mux
        logic [SEL_W-1:0]    sel;
        logic [MUX_SIZE-1:0] ins;

        assign sel = active[k*SEL_W +: SEL_W];
        assign ins = mux_in[k*MUX_SIZE +: MUX_SIZE];
        // Select codes beyond the last input (non-power-of-2 sizes) park the track low.
        assign mux_out[k] = (int'(sel) < MUX_SIZE) ? ins[sel] : 1'b0;
    end

    assign pass_out  = pass_in;
    assign ccff_tail = chain[TOTAL_BITS-1];

endmodule

// File: tb/tb_sb_ccff_param.sv
// Randomized self-checking bench for sb_ccff_param (4x4 and 4x3 mux instances sharing one chain stimulus).
// Honours SB_CFG_SHADOW_EN the same way as the design.
module tb_sb_ccff_param;

    logic        prog_clk;
    logic        prog_reset_n;
    logic        ccff_head;
    logic        ccff_en;
    logic        cfg_commit;
    logic [15:0] mux_in;
    logic [11:0] mux_in3;
    logic [8:0]  pass_in;
    logic [3:0]  mux_out;
    logic [3:0]  mux_out3;
    logic [8:0]  pass_out;
    logic [8:0]  pass_out3;
    logic        ccff_tail;
    logic        ccff_tail3;
    logic        cfg_done;
    logic        cfg_done3;

    int checks;
    int failures;

    bit          m_q[$];
    int          m_cnt;
    bit          m_done;
    logic [7:0]  m_shadow;

    sb_ccff_param #(.NUM_MUX(4), .MUX_SIZE(4), .CHAN_WIDTH(9)) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .ccff_head    (ccff_head),
        .ccff_en      (ccff_en),
        .cfg_commit   (cfg_commit),
        .mux_in       (mux_in),
        .pass_in      (pass_in),
        .mux_out      (mux_out),
        .pass_out     (pass_out),
        .ccff_tail    (ccff_tail),
        .cfg_done     (cfg_done)
    );

    sb_ccff_param #(.NUM_MUX(4), .MUX_SIZE(3), .CHAN_WIDTH(9)) dut3 (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .ccff_head    (ccff_head),
        .ccff_en      (ccff_en),
        .cfg_commit   (cfg_commit),
        .mux_in       (mux_in3),
        .pass_in      (pass_in),
        .mux_out      (mux_out3),
        .pass_out     (pass_out3),
        .ccff_tail    (ccff_tail3),
        .cfg_done     (cfg_done3)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // The model keeps the last eight bits shifted in, oldest first; oldest is the chain MSB.
    function automatic logic [7:0] m_chain();
        logic [7:0] c;
        for (int i = 0; i < 8; i++) c[i] = m_q[7-i];
        return c;
    endfunction

    function automatic void m_reset();
        m_q = {};
        for (int i = 0; i < 8; i++) m_q.push_back(1'b0);
        m_cnt    = 0;
        m_done   = 1'b0;
        m_shadow = '0;
    endfunction

    function automatic void m_step(input bit rst_n, input bit en, input bit head, input bit commit);
        bit took;
        took = 1'b0;
        if (!rst_n) begin
            m_reset();
            return;
        end
`ifdef SB_CFG_SHADOW_EN
        if (commit && m_done) begin
            m_shadow = m_chain();
            m_cnt    = 0;
            m_done   = 1'b0;
            took     = 1'b1;
        end
`else
        took = commit & 1'b0;
`endif
        if (en) begin
            m_q.push_back(head);
            void'(m_q.pop_front());
            if (!took) begin
                if (m_cnt < 8) m_cnt++;
                if (m_cnt == 8) m_done = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] m_active();
`ifdef SB_CFG_SHADOW_EN
        return m_shadow;
`else
        return m_chain();
`endif
    endfunction

    function automatic logic [3:0] exp_mux(input logic [7:0] act, input logic [15:0] ins, input int msize);
        logic [3:0] r;
        int sel;
        for (int k = 0; k < 4; k++) begin
            sel  = int'(act[2*k +: 2]);
            r[k] = (sel < msize) ? ins[k*msize + sel] : 1'b0;
        end
        return r;
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, ".tail"}, 32'(ccff_tail), 32'(m_q[0]));
        checkOutput({tag, ".tail3"}, 32'(ccff_tail3), 32'(m_q[0]));
        checkOutput({tag, ".done"}, 32'(cfg_done), 32'(m_done));
        checkOutput({tag, ".done3"}, 32'(cfg_done3), 32'(m_done));
        checkOutput({tag, ".mux"}, 32'(mux_out), 32'(exp_mux(m_active(), mux_in, 4)));
        checkOutput({tag, ".mux3"}, 32'(mux_out3), 32'(exp_mux(m_active(), {4'h0, mux_in3}, 3)));
        checkOutput({tag, ".pass"}, 32'(pass_out), 32'(pass_in));
    endtask

    task automatic applyStimulus(input bit rst_n, input bit en, input bit head, input bit commit,
                                 input string tag);
        prog_reset_n = rst_n;
        ccff_en      = en;
        ccff_head    = head;
        cfg_commit   = commit;
        m_step(rst_n, en, head, commit);
        @(posedge prog_clk);
        #1;
        checkAll(tag);
    endtask

    task automatic randomizeData();
        mux_in  = 16'($urandom);
        mux_in3 = 12'($urandom);
        pass_in = 9'($urandom);
    endtask

    initial begin
        bit seq[12];
        checks   = 0;
        failures = 0;
        seq = '{1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 1, 1};
        m_reset();
        prog_reset_n = 1'b0;
        ccff_en      = 1'b0;
        ccff_head    = 1'b0;
        cfg_commit   = 1'b0;
        randomizeData();

        // Reset state, with enables and commit asserted to show they are ignored.
        applyStimulus(0, 1, 1, 1, "reset0");
        applyStimulus(0, 0, 0, 0, "reset1");
        checkOutput("reset_mux_in0", 32'(mux_out),
                    32'({mux_in[12], mux_in[8], mux_in[4], mux_in[0]}));

        // Load the reference pattern: sels 0,3,1,2.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, seq[i], 0, "load");
            checkOutput("load_done", 32'(cfg_done), 32'(i == 7));
        end
        mux_in  = 16'h4281;
        mux_in3 = 12'hFFF;
        #1;
`ifdef SB_CFG_SHADOW_EN
        checkOutput("onehot_precommit", 32'(mux_out), 32'h1);
        checkOutput("size3_precommit", 32'(mux_out3), 32'hF);
        applyStimulus(1, 0, 0, 1, "commit");
        checkOutput("onehot_commit", 32'(mux_out), 32'hF);
        checkOutput("size3_sel3_zero", 32'(mux_out3), 32'hD);
        checkOutput("commit_done_clr", 32'(cfg_done), 32'h0);
`else
        checkOutput("onehot_live", 32'(mux_out), 32'hF);
        checkOutput("size3_sel3_zero", 32'(mux_out3), 32'hD);
        applyStimulus(1, 0, 0, 1, "commit_ignored");
        checkOutput("commit_done_kept", 32'(cfg_done), 32'h1);
`endif

        // Over-shift: counter saturates, tail replays the earliest bits.
        applyStimulus(0, 0, 0, 0, "rst_sat");
        for (int i = 0; i < 12; i++) begin
            randomizeData();
            applyStimulus(1, 1, seq[i], 0, "sat");
            if (i >= 7) checkOutput("sat_tail", 32'(ccff_tail), 32'(seq[i-7]));
        end

        // Commit while not fully loaded is ignored; counter keeps its 3.
        applyStimulus(0, 0, 0, 0, "rst_early");
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1'($urandom), 0, "early");
        applyStimulus(1, 0, 0, 1, "early_commit");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 1'($urandom), 0, "early_rest");
            checkOutput("early_rest_done", 32'(cfg_done), 32'(i == 4));
        end

        // Reset mid-load discards partial bits.
        applyStimulus(0, 0, 0, 0, "rst_mid");
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1'b1, 0, "mid");
        applyStimulus(0, 1, 1, 0, "mid_reset");
        checkOutput("mid_tail", 32'(ccff_tail), 32'h0);
        checkOutput("mid_done", 32'(cfg_done), 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            randomizeData();
            applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 7),
                          1'($urandom), ($urandom_range(0, 9) == 0), "rand");
        end

        pass_in = 9'h1A5;
        #1;
        checkOutput("pass_1a5", 32'(pass_out), 32'h1A5);
        checkOutput("pass3_1a5", 32'(pass_out3), 32'h1A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
